// File: rtl/debug_display_arbiter.sv
// Round-robin time-sharing of the debug LED display: each owner is held for a
// minimum dwell, and a blank gap separates consecutive owners.
module debug_display_arbiter #(
    parameter int               WIDTH        = 8,
    parameter int               N_REQ        = 4,
    parameter int               DWELL_CYCLES = 1024*1024*50,
    parameter int               GAP_CYCLES   = 1024*1024*5,
    parameter logic [WIDTH-1:0] IDLE_PATTERN = '0
) (
    input  logic                         clk,
    input  logic                         i_reset,
    input  logic [N_REQ-1:0]             i_req,
    input  logic [N_REQ-1:0][WIDTH-1:0]  i_data,
    input  logic                         i_lock,
    output logic [WIDTH-1:0]             o_data,
    output logic [N_REQ-1:0]             o_grant,
    output logic                         o_valid,
    output logic                         o_blank
);
    localparam int MAX_CYCLES = (DWELL_CYCLES > GAP_CYCLES) ? DWELL_CYCLES : GAP_CYCLES;
    localparam int CW = $clog2(MAX_CYCLES + 1);
    localparam int IW = $clog2(N_REQ);
    localparam logic [CW-1:0] DWELL_LAST = CW'(DWELL_CYCLES - 1);
    localparam logic [CW-1:0] GAP_LAST   = CW'(GAP_CYCLES - 1);
    localparam logic [IW-1:0] LAST_RESET = IW'(N_REQ - 1);

    typedef enum logic [1:0] {IDLE, SHOW, GAP} state_t;

    state_t           r_state;
    state_t           w_nextState;
    logic [CW-1:0]    r_count;
    logic [IW-1:0]    r_last;
    logic             w_found;
    logic [IW-1:0]    w_winner;
    logic [IW-1:0]    w_nextOwner;
    logic             w_ownerReq;
    logic             w_otherReq;
    logic             w_newGrant;
    logic             w_countClear;
    logic [WIDTH-1:0] w_nextData;
    logic [N_REQ-1:0] w_nextGrant;

    // While in SHOW, o_grant is the one-hot of the current owner.
    assign w_ownerReq  = |(i_req & o_grant);
    assign w_otherReq  = |(i_req & ~o_grant);
    assign w_nextOwner = w_newGrant ? w_winner : r_last;

    // Search last+1, last+2, ... wrapping, with last itself tried at the end.
    always_comb begin : pickWinner
        logic [IW-1:0] idx;
        idx      = '0;
        w_found  = 1'b0;
        w_winner = '0;
        for (int i = 1; i <= N_REQ; i++) begin
            idx = IW'((int'(r_last) + i) % N_REQ);
            if (!w_found && i_req[idx]) begin
                w_found  = 1'b1;
                w_winner = idx;
            end
        end
    end

    always_comb begin : nextState
        w_nextState  = r_state;
        w_newGrant   = 1'b0;
        w_countClear = 1'b0;
        case (r_state)
            IDLE: begin
                w_countClear = 1'b1;
                if (w_found) begin
                    w_nextState = SHOW;
                    w_newGrant  = 1'b1;
                end
            end
            SHOW: begin
                // A dropped owner leaves at once; the lock only protects an owner still requesting.
                if (!w_ownerReq) begin
                    w_nextState  = w_otherReq ? GAP : IDLE;
                    w_countClear = 1'b1;
                end else if (r_count == DWELL_LAST) begin
                    w_countClear = 1'b1;
                    if (!i_lock && w_otherReq)
                        w_nextState = GAP;
                end
            end
            GAP: begin
                if (r_count == GAP_LAST) begin
                    w_countClear = 1'b1;
                    if (w_found) begin
                        w_nextState = SHOW;
                        w_newGrant  = 1'b1;
                    end else begin
                        w_nextState = IDLE;
                    end
                end
            end
            default: begin
                w_nextState  = IDLE;
                w_countClear = 1'b1;
            end
        endcase
    end

    always_comb begin : nextOutputs
        w_nextData  = IDLE_PATTERN;
        w_nextGrant = '0;
        case (w_nextState)
            SHOW: begin
                w_nextData  = i_data[w_nextOwner];
                w_nextGrant = N_REQ'(1) << w_nextOwner;
            end
            GAP:     w_nextData = '0;
            default: w_nextData = IDLE_PATTERN;
        endcase
    end

    always_ff @(posedge clk) begin
        if (i_reset) begin
            r_state <= IDLE;
            r_count <= '0;
            r_last  <= LAST_RESET;
            o_data  <= IDLE_PATTERN;
            o_grant <= '0;
            o_valid <= 1'b0;
            o_blank <= 1'b0;
        end else begin
            r_state <= w_nextState;
            r_count <= w_countClear ? '0 : r_count + 1'b1;
            if (w_newGrant)
                r_last <= w_winner;
            o_data  <= w_nextData;
            o_grant <= w_nextGrant;
            o_valid <= (w_nextState == SHOW);
            o_blank <= (w_nextState == GAP);
        end
    end

endmodule

// File: tb/tb_debug_display_arbiter.sv
// Scoreboard bench for debug_display_arbiter: expected per-cycle outputs are
// queued with the stimulus and popped as each registered output appears.
module tb_debug_display_arbiter;
    localparam logic [7:0] IDLE_PAT = 8'h81;

    logic            clk = 1'b0;
    logic            i_reset;
    logic [3:0]      i_req;
    logic [3:0][7:0] i_data;
    logic            i_lock;
    logic [7:0]      o_data;
    logic [3:0]      o_grant;
    logic            o_valid;
    logic            o_blank;

    typedef struct packed {
        logic [3:0] grant;
        logic [7:0] data;
        logic       valid;
        logic       blank;
    } obs_t;

    obs_t expQ[$];
    int   total = 0;
    int   bad   = 0;

    debug_display_arbiter #(
        .WIDTH(8), .N_REQ(4), .DWELL_CYCLES(4), .GAP_CYCLES(2), .IDLE_PATTERN(IDLE_PAT)
    ) dut (
        .clk(clk), .i_reset(i_reset), .i_req(i_req), .i_data(i_data), .i_lock(i_lock),
        .o_data(o_data), .o_grant(o_grant), .o_valid(o_valid), .o_blank(o_blank)
    );

    always #5 clk = ~clk;

    task automatic pushExp(input int n, input logic [3:0] g, input logic [7:0] d,
                           input logic v, input logic b);
        for (int i = 0; i < n; i++) expQ.push_back('{g, d, v, b});
    endtask

    task automatic pushShow(input int n, input logic [3:0] g, input logic [7:0] d);
        pushExp(n, g, d, 1'b1, 1'b0);
    endtask

    task automatic pushGap(input int n);
        pushExp(n, 4'b0000, 8'h00, 1'b0, 1'b1);
    endtask

    task automatic pushIdle(input int n);
        pushExp(n, 4'b0000, IDLE_PAT, 1'b0, 1'b0);
    endtask

    task automatic applyStimulus(input logic [3:0] req, input logic lock);
        i_req  = req;
        i_lock = lock;
    endtask

    task automatic sampleOutput(output obs_t want, output obs_t got);
        @(posedge clk);
        #1;
        got = '{o_grant, o_data, o_valid, o_blank};
        if (expQ.size() != 0) want = expQ.pop_front();
        else want = 'x;
    endtask

    task automatic doReset();
        i_reset = 1'b1;
        applyStimulus(4'b0000, 1'b0);
        repeat (2) @(posedge clk);
        #1;
        i_reset = 1'b0;
    endtask

    task automatic test_reset();
        obs_t want, got;
        i_reset = 1'b1;
        i_data  = {8'h44, 8'h33, 8'h22, 8'h11};
        applyStimulus(4'b1111, 1'b0);
        pushIdle(3);
        pushShow(1, 4'b0001, 8'h11);
        for (int i = 0; i < 4; i++) begin
            sampleOutput(want, got);
            total++;
            if (got !== want) begin
                bad++;
                $display("[TB] FAIL reset[%0d]: got g=%b d=%h v=%b b=%b, want g=%b d=%h v=%b b=%b",
                         i, got.grant, got.data, got.valid, got.blank,
                         want.grant, want.data, want.valid, want.blank);
            end
            if (i == 2) i_reset = 1'b0;
        end
    endtask

    task automatic test_single();
        obs_t want, got;
        doReset();
        i_data[2] = 8'hA5;
        applyStimulus(4'b0100, 1'b0);
        pushShow(12, 4'b0100, 8'hA5);
        pushShow(2, 4'b0100, 8'h3C);
        for (int i = 0; i < 14; i++) begin
            sampleOutput(want, got);
            total++;
            if (got !== want) begin
                bad++;
                $display("[TB] FAIL single[%0d]: got g=%b d=%h v=%b b=%b, want g=%b d=%h v=%b b=%b",
                         i, got.grant, got.data, got.valid, got.blank,
                         want.grant, want.data, want.valid, want.blank);
            end
            if (i == 11) i_data[2] = 8'h3C;
        end
    endtask

    task automatic test_round_robin();
        obs_t want, got;
        doReset();
        i_data = {8'h40, 8'h30, 8'h20, 8'h10};
        applyStimulus(4'b1011, 1'b0);
        pushShow(4, 4'b0001, 8'h10); pushGap(2);
        pushShow(4, 4'b0010, 8'h20); pushGap(2);
        pushShow(4, 4'b1000, 8'h40); pushGap(2);
        pushShow(4, 4'b0001, 8'h10);
        for (int i = 0; i < 22; i++) begin
            sampleOutput(want, got);
            total++;
            if (got !== want) begin
                bad++;
                $display("[TB] FAIL roundrobin[%0d]: got g=%b d=%h v=%b b=%b, want g=%b d=%h v=%b b=%b",
                         i, got.grant, got.data, got.valid, got.blank,
                         want.grant, want.data, want.valid, want.blank);
            end
        end
    endtask

    task automatic test_early_drop();
        obs_t want, got;
        doReset();
        i_data = {8'h40, 8'h30, 8'h20, 8'h10};
        applyStimulus(4'b0010, 1'b0);
        pushShow(2, 4'b0010, 8'h20);
        pushGap(2);
        pushShow(1, 4'b1000, 8'h40);
        pushIdle(2);
        for (int i = 0; i < 7; i++) begin
            sampleOutput(want, got);
            total++;
            if (got !== want) begin
                bad++;
                $display("[TB] FAIL earlydrop[%0d]: got g=%b d=%h v=%b b=%b, want g=%b d=%h v=%b b=%b",
                         i, got.grant, got.data, got.valid, got.blank,
                         want.grant, want.data, want.valid, want.blank);
            end
            if (i == 0) applyStimulus(4'b1010, 1'b0);
            if (i == 1) applyStimulus(4'b1000, 1'b0);
            if (i == 4) applyStimulus(4'b0000, 1'b0);
        end
    endtask

    task automatic test_lock();
        obs_t want, got;
        doReset();
        i_data = {8'h40, 8'h30, 8'h20, 8'h10};
        applyStimulus(4'b0011, 1'b1);
        pushShow(8, 4'b0001, 8'h10);
        pushGap(2);
        pushShow(1, 4'b0010, 8'h20);
        for (int i = 0; i < 11; i++) begin
            sampleOutput(want, got);
            total++;
            if (got !== want) begin
                bad++;
                $display("[TB] FAIL lock[%0d]: got g=%b d=%h v=%b b=%b, want g=%b d=%h v=%b b=%b",
                         i, got.grant, got.data, got.valid, got.blank,
                         want.grant, want.data, want.valid, want.blank);
            end
            if (i == 7) applyStimulus(4'b0010, 1'b1);
        end
        applyStimulus(4'b0010, 1'b0);
    endtask

    task automatic test_reset_mid();
        obs_t want, got;
        doReset();
        i_data = {8'h40, 8'h30, 8'h20, 8'h10};
        applyStimulus(4'b0010, 1'b0);
        pushShow(3, 4'b0010, 8'h20);
        pushIdle(1);
        pushShow(1, 4'b0001, 8'h10);
        for (int i = 0; i < 5; i++) begin
            sampleOutput(want, got);
            total++;
            if (got !== want) begin
                bad++;
                $display("[TB] FAIL resetmid[%0d]: got g=%b d=%h v=%b b=%b, want g=%b d=%h v=%b b=%b",
                         i, got.grant, got.data, got.valid, got.blank,
                         want.grant, want.data, want.valid, want.blank);
            end
            if (i == 2) i_reset = 1'b1;
            if (i == 3) begin
                i_reset = 1'b0;
                applyStimulus(4'b0011, 1'b0);
            end
        end
    endtask

    initial begin
        test_reset();
        test_single();
        test_round_robin();
        test_early_drop();
        test_lock();
        test_reset_mid();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
